// File: rtl/multi_cycle_ctrl_pkg.sv
// multi_cycle_ctrl_pkg: shared state, instruction-class, opcode/funct, ALU and PC-select encodings
package multi_cycle_ctrl_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [3:0] {C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_ILL} iclass_t;
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_SUBU = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_ADDV = 3'b100;
  localparam logic [2:0] ALU_LUI  = 3'b101;
  localparam logic [1:0] PC_4     = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;
  localparam logic [1:0] PC_RS    = 2'b11;
endpackage

// File: rtl/mips_decode.sv
// mips_decode: maps an instruction word to its class and EXEC-phase ALU controls
module mips_decode import multi_cycle_ctrl_pkg::*; (
  input  logic [31:0] order,
  output iclass_t     iclass,
  output logic [2:0]  sel_alu,
  output logic        imm,
  output logic        ext,
  output logic        lui,
  output logic        addi
);
  logic [5:0] op, fn;
  assign op = order[31:26];
  assign fn = order[5:0];
  always_comb begin
    iclass  = C_ILL;
    sel_alu = ALU_ADDU;
    imm     = 1'b0;
    ext     = 1'b0;
    lui     = 1'b0;
    addi    = 1'b0;
    case (op)
      OP_R: case (fn)
        FN_ADDU: iclass = C_RALU;
        FN_SUBU: begin iclass = C_RALU; sel_alu = ALU_SUBU; end
        FN_SLT:  begin iclass = C_RALU; sel_alu = ALU_SLT; end
        FN_JR:   iclass = C_JR;
        default: iclass = C_ILL;
      endcase
      OP_ADDI:  begin iclass = C_IALU; sel_alu = ALU_ADDV; imm = 1'b1; addi = 1'b1; end
      OP_ADDIU: begin iclass = C_IALU; imm = 1'b1; end
      OP_ORI:   begin iclass = C_IALU; sel_alu = ALU_OR; imm = 1'b1; end
      OP_LUI:   begin iclass = C_IALU; sel_alu = ALU_LUI; imm = 1'b1; lui = 1'b1; end
      OP_LW:    begin iclass = C_LW; imm = 1'b1; ext = 1'b1; end
      OP_SW:    begin iclass = C_SW; imm = 1'b1; ext = 1'b1; end
      OP_BEQ:   begin iclass = C_BEQ; sel_alu = ALU_SUBU; end
      OP_J:     iclass = C_J;
      OP_JAL:   iclass = C_JAL;
      default:  iclass = C_ILL;
    endcase
  end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: five-state multi-cycle MIPS control FSM with retired-instruction counter
module multi_cycle_ctrl import multi_cycle_ctrl_pkg::*; #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      order,
  input  logic             zero,
  input  logic             ovf,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_write,
  output logic             ir_write,
  output logic [1:0]       pc_src,
  output logic [2:0]       sel_ALU,
  output logic             rd,
  output logic             imm_to_ALU,
  output logic             Extop,
  output logic             lui,
  output logic             jal,
  output logic             GPR_write,
  output logic             RAM_write,
  output logic             RAM_to_GPR,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  iclass_t          iclass;
  logic [2:0]       dec_alu;
  logic             dec_imm, dec_ext, dec_lui, dec_addi;
  mips_decode u_dec (
    .order   (order),
    .iclass  (iclass),
    .sel_alu (dec_alu),
    .imm     (dec_imm),
    .ext     (dec_ext),
    .lui     (dec_lui),
    .addi    (dec_addi)
  );
  always_ff @(posedge clk) begin
    state_q   <= rst ? FETCH : state_d;
    retired_q <= rst ? '0 : retired_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE:  state_d = iclass == C_ILL ? FETCH : EXEC;
      EXEC:    state_d = iclass inside {C_RALU, C_IALU} ? WB : iclass inside {C_LW, C_SW} ? MEM : FETCH;
      MEM:     state_d = !mem_ready ? MEM : iclass == C_LW ? WB : FETCH;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end
  assign retired_d = retired_q + CNT_W'(state_q inside {EXEC, MEM, WB} && state_d == FETCH);
  assign retired   = rst ? '0 : retired_q;
  always_comb begin
    mem_req    = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    pc_src     = PC_4;
    sel_ALU    = ALU_ADDU;
    rd         = 1'b0;
    imm_to_ALU = 1'b0;
    Extop      = 1'b0;
    lui        = 1'b0;
    jal        = 1'b0;
    GPR_write  = 1'b0;
    RAM_write  = 1'b0;
    RAM_to_GPR = 1'b0;
    illegal    = 1'b0;
    if (!rst) case (state_q)
      FETCH: begin
        mem_req  = 1'b1;
        pc_write = mem_ready;
        ir_write = mem_ready;
      end
      DECODE: illegal = iclass == C_ILL;
      EXEC: begin
        sel_ALU    = dec_alu;
        imm_to_ALU = dec_imm;
        Extop      = dec_ext;
        lui        = dec_lui;
        pc_write   = (iclass == C_BEQ && zero) || iclass inside {C_J, C_JAL, C_JR};
        pc_src     = iclass == C_BEQ ? (zero ? PC_BR : PC_4) :
                     iclass == C_JR ? PC_RS : iclass inside {C_J, C_JAL} ? PC_JMP : PC_4;
        jal        = iclass == C_JAL;
        GPR_write  = iclass == C_JAL;
      end
      MEM: begin
        mem_req   = 1'b1;
        RAM_write = iclass == C_SW;
      end
      WB: begin
        rd         = iclass == C_RALU;
        RAM_to_GPR = iclass == C_LW;
        GPR_write  = !(dec_addi && ovf);
      end
      default: mem_req = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: table-driven per-cycle check of multi_cycle_ctrl outputs
module tb_multi_cycle_ctrl;
  typedef struct packed {
    logic       mem_req, pc_write, ir_write;
    logic [1:0] pc_src;
    logic [2:0] sel_alu;
    logic       rd, imm, ext, lui, jal, gpr, ramw, r2g, ill;
  } ctrl_t;
  typedef struct {
    logic        r;
    logic [31:0] o;
    logic        z, ov, mr;
    ctrl_t       c;
    int unsigned ret;
  } vec_t;
  localparam logic [31:0] ADDU  = 32'h0022_1821;
  localparam logic [31:0] SUBU  = 32'h0022_1823;
  localparam logic [31:0] SLT   = 32'h0022_182A;
  localparam logic [31:0] BADFN = 32'h0022_183F;
  localparam logic [31:0] JR    = 32'h03E0_0008;
  localparam logic [31:0] LW    = 32'h8C22_0004;
  localparam logic [31:0] SW    = 32'hAC22_0004;
  localparam logic [31:0] BEQ   = 32'h1022_0008;
  localparam logic [31:0] ADDI  = 32'h2022_0001;
  localparam logic [31:0] ADDIU = 32'h2422_0001;
  localparam logic [31:0] ORI   = 32'h3422_0005;
  localparam logic [31:0] LUI   = 32'h3C02_0001;
  localparam logic [31:0] J     = 32'h0800_0010;
  localparam logic [31:0] JAL   = 32'h0C00_0010;
  localparam logic [31:0] ILL   = 32'hFC00_0000;
  localparam ctrl_t N   = '0;
  localparam ctrl_t FW  = ctrl_t'{mem_req: 1'b1, default: '0};
  localparam ctrl_t FG  = ctrl_t'{mem_req: 1'b1, pc_write: 1'b1, ir_write: 1'b1, default: '0};
  localparam ctrl_t MR  = ctrl_t'{mem_req: 1'b1, default: '0};
  localparam ctrl_t MW  = ctrl_t'{mem_req: 1'b1, ramw: 1'b1, default: '0};
  localparam ctrl_t IL  = ctrl_t'{ill: 1'b1, default: '0};
  localparam ctrl_t WR  = ctrl_t'{rd: 1'b1, gpr: 1'b1, default: '0};
  localparam ctrl_t WI  = ctrl_t'{gpr: 1'b1, default: '0};
  localparam ctrl_t EM  = ctrl_t'{imm: 1'b1, ext: 1'b1, default: '0};
  logic        clk = 1'b0, rst = 1'b1, zero = 1'b0, ovf = 1'b0, mem_ready = 1'b0;
  logic [31:0] order = 32'h0;
  logic        mem_req, pc_write, ir_write, rd, imm_to_ALU, Extop, lui, jal;
  logic        GPR_write, RAM_write, RAM_to_GPR, illegal;
  logic [1:0]  pc_src;
  logic [2:0]  sel_ALU;
  logic [31:0] retired;
  ctrl_t       act;
  vec_t        tbl[$];
  int          checks = 0, fails = 0;
  multi_cycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .order(order), .zero(zero), .ovf(ovf), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_write(pc_write), .ir_write(ir_write), .pc_src(pc_src),
    .sel_ALU(sel_ALU), .rd(rd), .imm_to_ALU(imm_to_ALU), .Extop(Extop), .lui(lui),
    .jal(jal), .GPR_write(GPR_write), .RAM_write(RAM_write), .RAM_to_GPR(RAM_to_GPR),
    .illegal(illegal), .retired(retired)
  );
  assign act = {mem_req, pc_write, ir_write, pc_src, sel_ALU, rd, imm_to_ALU, Extop, lui,
                jal, GPR_write, RAM_write, RAM_to_GPR, illegal};
  always #5 clk = ~clk;
  function automatic void add(logic r, logic [31:0] o, logic z, logic ov, logic mr, ctrl_t c, int unsigned ret);
    vec_t v;
    v = '{r: r, o: o, z: z, ov: ov, mr: mr, c: c, ret: ret};
    tbl.push_back(v);
  endfunction
  function automatic void fd(logic [31:0] o, int unsigned ret);
    add(1'b0, o, 1'b0, 1'b0, 1'b1, FG, ret);
    add(1'b0, o, 1'b0, 1'b0, 1'b1, N, ret);
  endfunction
  initial begin
    add(1'b1, ADDU, 1'b0, 1'b0, 1'b1, N, 0);
    fd(ADDU, 0);
    add(1'b0, ADDU, 1'b0, 1'b0, 1'b1, N, 0);
    add(1'b0, ADDU, 1'b0, 1'b0, 1'b1, WR, 0);
    fd(LW, 1);
    add(1'b0, LW, 1'b0, 1'b0, 1'b1, EM, 1);
    for (int k = 0; k < 3; k++) add(1'b0, LW, 1'b0, 1'b0, 1'b0, MR, 1);
    add(1'b0, LW, 1'b0, 1'b0, 1'b1, MR, 1);
    add(1'b0, LW, 1'b0, 1'b0, 1'b1, ctrl_t'{gpr: 1'b1, r2g: 1'b1, default: '0}, 1);
    fd(BEQ, 2);
    add(1'b0, BEQ, 1'b1, 1'b0, 1'b1, ctrl_t'{pc_write: 1'b1, pc_src: 2'b01, sel_alu: 3'b001, default: '0}, 2);
    fd(BEQ, 3);
    add(1'b0, BEQ, 1'b0, 1'b0, 1'b1, ctrl_t'{sel_alu: 3'b001, default: '0}, 3);
    fd(ADDI, 4);
    add(1'b0, ADDI, 1'b0, 1'b0, 1'b1, ctrl_t'{sel_alu: 3'b100, imm: 1'b1, default: '0}, 4);
    add(1'b0, ADDI, 1'b0, 1'b1, 1'b1, N, 4);
    fd(ADDI, 5);
    add(1'b0, ADDI, 1'b0, 1'b0, 1'b1, ctrl_t'{sel_alu: 3'b100, imm: 1'b1, default: '0}, 5);
    add(1'b0, ADDI, 1'b0, 1'b0, 1'b1, WI, 5);
    add(1'b0, ILL, 1'b0, 1'b0, 1'b0, FW, 6);
    add(1'b0, ILL, 1'b0, 1'b0, 1'b1, FG, 6);
    add(1'b0, ILL, 1'b0, 1'b0, 1'b1, IL, 6);
    fd(J, 6);
    add(1'b0, J, 1'b0, 1'b0, 1'b1, ctrl_t'{pc_write: 1'b1, pc_src: 2'b10, default: '0}, 6);
    fd(JAL, 7);
    add(1'b0, JAL, 1'b0, 1'b0, 1'b1, ctrl_t'{pc_write: 1'b1, pc_src: 2'b10, jal: 1'b1, gpr: 1'b1, default: '0}, 7);
    fd(JR, 8);
    add(1'b0, JR, 1'b0, 1'b0, 1'b1, ctrl_t'{pc_write: 1'b1, pc_src: 2'b11, default: '0}, 8);
    fd(ORI, 9);
    add(1'b0, ORI, 1'b0, 1'b0, 1'b1, ctrl_t'{sel_alu: 3'b010, imm: 1'b1, default: '0}, 9);
    add(1'b0, ORI, 1'b0, 1'b0, 1'b1, WI, 9);
    fd(LUI, 10);
    add(1'b0, LUI, 1'b0, 1'b0, 1'b1, ctrl_t'{sel_alu: 3'b101, imm: 1'b1, lui: 1'b1, default: '0}, 10);
    add(1'b0, LUI, 1'b0, 1'b0, 1'b1, WI, 10);
    fd(SUBU, 11);
    add(1'b0, SUBU, 1'b0, 1'b0, 1'b1, ctrl_t'{sel_alu: 3'b001, default: '0}, 11);
    add(1'b0, SUBU, 1'b0, 1'b0, 1'b1, WR, 11);
    fd(SLT, 12);
    add(1'b0, SLT, 1'b0, 1'b0, 1'b1, ctrl_t'{sel_alu: 3'b011, default: '0}, 12);
    add(1'b0, SLT, 1'b0, 1'b0, 1'b1, WR, 12);
    fd(ADDIU, 13);
    add(1'b0, ADDIU, 1'b0, 1'b0, 1'b1, ctrl_t'{imm: 1'b1, default: '0}, 13);
    add(1'b0, ADDIU, 1'b0, 1'b0, 1'b1, WI, 13);
    fd(SW, 14);
    add(1'b0, SW, 1'b0, 1'b0, 1'b1, EM, 14);
    add(1'b0, SW, 1'b0, 1'b0, 1'b0, MW, 14);
    add(1'b0, SW, 1'b0, 1'b0, 1'b1, MW, 14);
    add(1'b0, BADFN, 1'b0, 1'b0, 1'b1, FG, 15);
    add(1'b0, BADFN, 1'b0, 1'b0, 1'b1, IL, 15);
    fd(SW, 15);
    add(1'b0, SW, 1'b0, 1'b0, 1'b1, EM, 15);
    add(1'b0, SW, 1'b0, 1'b0, 1'b0, MW, 15);
    add(1'b1, SW, 1'b0, 1'b0, 1'b0, N, 0);
    add(1'b0, SW, 1'b0, 1'b0, 1'b0, FW, 0);
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].r;
      order = tbl[i].o;
      zero = tbl[i].z;
      ovf = tbl[i].ov;
      mem_ready = tbl[i].mr;
      #1;
      checks++;
      if (act !== tbl[i].c) begin
        fails++;
        $display("FAIL row %0d ctrl: got %h expected %h", i, act, tbl[i].c);
      end
      checks++;
      if (retired !== tbl[i].ret) begin
        fails++;
        $display("FAIL row %0d retired: got %0d expected %0d", i, retired, tbl[i].ret);
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (act !== FW) begin
        fails++;
        $display("FAIL fetch_stall cycle %0d ctrl: got %h expected %h", k, act, FW);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port order, input, 32: instruction register contents; stable from the cycle after ir_write until the next ir_write.
REQ-005 Port zero, input, 1: ALU result-equals-zero flag.
REQ-006 Port ovf, input, 1: ALU signed-overflow flag.
REQ-007 Port mem_ready, input, 1: memory completes the current request this cycle.
REQ-008 Port mem_req, output, 1: memory access request.
REQ-009 Ports pc_write and ir_write, output, 1 each: PC and instruction register load enables.
REQ-010 Port pc_src, output, 2: next-PC select; 00 PC+4, 01 branch target, 10 jump target, 11 rs (jr).
REQ-011 Port sel_ALU, output, 3: ALU op; 000 addu, 001 subu, 010 or, 011 slt, 100 add with overflow, 101 lui.
REQ-012 Ports rd, imm_to_ALU, Extop, lui, jal, GPR_write, RAM_write, RAM_to_GPR, output, 1 each: datapath selects and write enables.
REQ-013 Port illegal, output, 1: one-cycle pulse on an unsupported opcode or funct.
REQ-014 Port retired, output, CNT_W: count of completed instructions.

Function
REQ-015 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB.
REQ-016 FETCH: mem_req=1 and pc_src=00 SHALL be asserted; when mem_ready=1, pc_write=1 and ir_write=1 for that cycle and the next state is DECODE; otherwise FETCH.
REQ-017 DECODE SHALL last one cycle with no write enables; the next state is FETCH with illegal=1 for unsupported encodings, otherwise EXEC.
REQ-018 Supported encodings: R-type funct addu, subu, slt, jr; opcodes addi, addiu, ori, lui, lw, sw, beq, j, jal.
REQ-019 EXEC: sel_ALU, imm_to_ALU, Extop and lui SHALL be driven per instruction (addi 100, addiu/lw/sw 000 with Extop=1 for lw/sw, ori 010, lui 101, beq 001).
REQ-020 EXEC next state: R-ALU and I-ALU go to WB; lw and sw go to MEM; beq, j, jal and jr go to FETCH.
REQ-021 EXEC beq SHALL assert pc_write with pc_src=01 only when zero=1.
REQ-022 EXEC j SHALL assert pc_write with pc_src=10; jal SHALL assert pc_write with pc_src=10, jal=1 and GPR_write=1; jr SHALL assert pc_write with pc_src=11.
REQ-023 MEM: mem_req=1 and, for sw, RAM_write=1 SHALL be held until mem_ready=1; then lw goes to WB and sw goes to FETCH.
REQ-024 WB: GPR_write=1 SHALL be asserted with rd=1 for R-type and rd=0 for I-type; RAM_to_GPR=1 for lw; next state FETCH.
REQ-025 addi with ovf=1 in WB SHALL suppress GPR_write.
REQ-026 retired SHALL increment by 1 on each exit to FETCH from EXEC, MEM or WB, wrapping modulo 2^CNT_W; an illegal exit from DECODE does not count.
REQ-027 Outputs SHALL be combinational from state, order, zero, ovf and mem_ready; every enable not named for a state is 0.
REQ-028 mem_ready asserted outside FETCH or MEM SHALL be ignored.

Reset
REQ-029 While rst=1, all outputs SHALL be 0; on the first edge with rst=1, state becomes FETCH and retired becomes 0.
REQ-030 rst asserted in any state, including mid-MEM with RAM_write high, SHALL abort the instruction with no further write enable.

Structure
REQ-031 A shared package SHALL hold the state encoding, opcode and funct constants, sel_ALU codes and pc_src codes.
REQ-032 The per-instruction decode (order to instruction class and EXEC controls) SHALL be one combinational sub-module, mips_decode; the FSM and counter stay in multi_cycle_ctrl.

Verification
REQ-033 addu $3,$1,$2 with mem_ready tied to 1 -> states FETCH, DECODE, EXEC, WB; sel_ALU=000, rd=1, GPR_write=1 in WB; retired 0->1.
REQ-034 lw with mem_ready low for 3 MEM cycles -> mem_req held for 4 MEM cycles; RAM_to_GPR=1 and GPR_write=1 in WB; 8 cycles total with a 1-cycle fetch.
REQ-035 beq with zero=1, then beq with zero=0 -> pc_write/pc_src=01 in EXEC only for the first; both retire.
REQ-036 addi with ovf=1 -> no GPR_write in WB; retired still increments.
REQ-037 opcode 6'b111111 -> illegal pulses once after DECODE; next state FETCH; retired unchanged.
REQ-038 sw with rst raised during the second MEM cycle -> RAM_write=0 from the next cycle; state FETCH; retired=0.
